// File: rtl/fft_mag_pkg.sv
// Shared types and widths for the FFT spectrum magnitude block.
package fft_mag_pkg;

  localparam int SRC_W = 16;
  localparam int ABS_W = SRC_W - 1;
  localparam int MAG_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_SKIP = 2'd2
  } state_t;

  // max + 3/8*min, with max, min in [0, 32767] this tops out at 45053 so MAG_W never overflows
  function automatic logic [MAG_W-1:0] alpha_max_beta_min(input logic [ABS_W-1:0] mx,
                                                          input logic [ABS_W-1:0] mn);
    return MAG_W'(mx) + MAG_W'(mn >> 2) + MAG_W'(mn >> 3);
  endfunction

endpackage

// File: rtl/fft_mag_approx.sv
// Three-stage alpha-max-beta-min magnitude pipeline with a valid/sop/eop sideband tag.
module fft_mag_approx
  import fft_mag_pkg::*;
#(
  parameter int DATA_W = SRC_W
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] src_re,
  input  logic [DATA_W-1:0] src_im,
  input  logic              beat_vld,
  input  logic              beat_sop,
  input  logic              beat_eop,
  output logic [MAG_W-1:0]  mag,
  output logic              mag_vld,
  output logic              mag_sop,
  output logic              mag_eop
);

  localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic        [DATA_W-2:0] are_p0, aim_p0;
  logic        [DATA_W-2:0] mx_p1, mn_p1;
  logic        [MAG_W-1:0]  mag_p2;
  logic                     vld_p0, vld_p1, vld_p2;
  logic                     sop_p0, sop_p1, sop_p2;
  logic                     eop_p0, eop_p1, eop_p2;
  logic signed [DATA_W-1:0] re_s, im_s;

  assign re_s = src_re;
  assign im_s = src_im;

  function automatic logic [DATA_W-2:0] abs_sat(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] neg;
    neg = -x;
    if (x == MOST_NEG) return {(DATA_W-1){1'b1}};
    else if (x < 0)    return neg[DATA_W-2:0];
    else               return x[DATA_W-2:0];
  endfunction

  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;  sop_p0 <= 1'b0;  eop_p0 <= 1'b0;
      vld_p1 <= 1'b0;  sop_p1 <= 1'b0;  eop_p1 <= 1'b0;
      vld_p2 <= 1'b0;  sop_p2 <= 1'b0;  eop_p2 <= 1'b0;
    end else begin
      vld_p0 <= beat_vld;  sop_p0 <= beat_sop;  eop_p0 <= beat_eop;
      vld_p1 <= vld_p0;    sop_p1 <= sop_p0;    eop_p1 <= eop_p0;
      vld_p2 <= vld_p1;    sop_p2 <= sop_p1;    eop_p2 <= eop_p1;
    end
  end

  always_ff @(posedge clk_50m) begin
    // stage p0: saturating absolute values
    are_p0 <= abs_sat(re_s);
    aim_p0 <= abs_sat(im_s);
    // stage p1: order the two components
    mx_p1  <= (are_p0 >= aim_p0) ? are_p0 : aim_p0;
    mn_p1  <= (are_p0 >= aim_p0) ? aim_p0 : are_p0;
    // stage p2: magnitude estimate
    mag_p2 <= alpha_max_beta_min(mx_p1, mn_p1);
  end

  assign mag     = mag_p2;
  assign mag_vld = vld_p2;
  assign mag_sop = sop_p2;
  assign mag_eop = eop_p2;

endmodule

// File: rtl/fft_spectrum_mag.sv
// Frames FFT source beats, forwards the leading OUT_BINS bins as magnitudes and flags framing faults.
module fft_spectrum_mag
  import fft_mag_pkg::*;
#(
  parameter int FFT_N    = 256,
  parameter int OUT_BINS = 128
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic [SRC_W-1:0] src_real,
  input  logic [SRC_W-1:0] src_imag,
  input  logic             src_valid,
  input  logic             src_sop,
  input  logic             src_eop,
  output logic [MAG_W-1:0] fft_data,
  output logic             fft_valid,
  output logic             fft_sop,
  output logic             fft_eop,
  output logic             frame_err,
  output logic [15:0]      frame_cnt
);

  localparam int               BIN_W     = $clog2(FFT_N);
  localparam logic [BIN_W-1:0] LAST_BIN  = BIN_W'(FFT_N - 1);
  localparam logic [BIN_W-1:0] PASS_LAST = BIN_W'(OUT_BINS - 1);
  localparam bit               FULL_PASS = (OUT_BINS == FFT_N);

  state_t           state, state_nxt, eff_state;
  logic [BIN_W-1:0] bin_cnt, bin_nxt, eff_bin;
  logic             fwd, fwd_sop, fwd_eop, err;
  logic [MAG_W-1:0] mag;
  logic             mag_vld, mag_sop, mag_eop;

  // A sop beat always restarts the frame at bin 0, whatever state it lands in
  assign eff_state = src_sop ? ST_PASS : state;
  assign eff_bin   = src_sop ? '0 : bin_cnt;

  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bin_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bin_cnt <= bin_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bin_nxt   = bin_cnt;
    if (src_valid) begin
      state_nxt = eff_state;
      bin_nxt   = eff_bin + 1'b1;
      case (eff_state)
        ST_PASS: begin
          if (src_eop || (eff_bin == PASS_LAST && FULL_PASS)) begin
            state_nxt = ST_IDLE;
            bin_nxt   = '0;
          end else if (eff_bin == PASS_LAST) begin
            state_nxt = ST_SKIP;
          end
        end
        ST_SKIP: begin
          if (src_eop || eff_bin == LAST_BIN) begin
            state_nxt = ST_IDLE;
            bin_nxt   = '0;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          bin_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    fwd     = 1'b0;
    fwd_sop = 1'b0;
    fwd_eop = 1'b0;
    err     = 1'b0;
    if (src_valid) begin
      err = src_sop && (state != ST_IDLE);
      case (eff_state)
        ST_PASS: begin
          fwd     = 1'b1;
          fwd_sop = src_sop;
          if (src_eop) begin
            fwd_eop = 1'b1;
            if (eff_bin != LAST_BIN) err = 1'b1;
          end else if (eff_bin == PASS_LAST) begin
            fwd_eop = 1'b1;
            if (FULL_PASS) err = 1'b1;
          end
        end
        ST_SKIP: begin
          if (src_eop) begin
            if (eff_bin != LAST_BIN) err = 1'b1;
          end else if (eff_bin == LAST_BIN) begin
            err = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  fft_mag_approx #(
    .DATA_W (SRC_W)
  ) u_mag (
    .clk_50m  (clk_50m),
    .rst_n    (rst_n),
    .src_re   (src_real),
    .src_im   (src_imag),
    .beat_vld (fwd),
    .beat_sop (fwd_sop),
    .beat_eop (fwd_eop),
    .mag      (mag),
    .mag_vld  (mag_vld),
    .mag_sop  (mag_sop),
    .mag_eop  (mag_eop)
  );

  assign fft_data  = mag_vld ? mag : '0;
  assign fft_valid = mag_vld;
  assign fft_sop   = mag_sop;
  assign fft_eop   = mag_eop;

  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      frame_err <= err;
      if (mag_vld && mag_eop) frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule
